seven_seg_scan_ctrl: RTL and testbench
======================================

# seven_seg_scan_ctrl

Sequential front end for the four-digit seven-segment driver. It generates the digit scan index at a fixed refresh rate and holds the displayed value, decimal points and digit enables in registers. Display updates are applied only at frame boundaries, so no digit shows a mix of old and new data. It also provides per-digit blinking and leading-zero suppression, and its outputs connect directly to the segment driver's hexnum/point/enable/scan inputs.

## Interface

Parameters:
- SCAN_DIV, default 100000, number of clock cycles each digit is shown (min 2)
- BLINK_FRAMES, default 125, number of frames per blink half-period (min 1)

Ports:
- clk  in  1  system clock; all state is updated on its rising edge
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- load  in  1  one-cycle request to update the display contents
- data_in  in  16  four hex digits; digit 0 is [3:0]
- point_in  in  4  decimal point per digit, active high
- enable_in  in  4  digit enable, active high
- blink_in  in  4  digits that blink, active high
- lz_blank  in  1  leading-zero suppression; sampled each cycle, not latched
- hexnum  out  16  committed digit value
- point  out  4  committed decimal points
- enable  out  4  effective digit enable after blink and leading-zero masking
- scan  out  2  index of the active digit
- frame_start  out  1  one-cycle pulse, high during the first cycle of scan==0
- pending  out  1  an accepted load is waiting for the next frame boundary

## Operation

- **Divider.** div counts 0..SCAN_DIV-1 and wraps. tick = (div==SCAN_DIV-1). On each tick, scan increments modulo 4.
- **Frame boundary.** A boundary is a cycle where tick is high and scan==3.
- **Load capture.** When load=1, data_in, point_in, enable_in and blink_in are captured into the shadow registers, and pending is set. A later load before the boundary overwrites the shadow, so the last load wins.
- **Commit.** At a frame boundary with pending=1, the shadow registers are copied into the committed registers and pending is cleared.
- **Load on the boundary cycle.** If load=1 on the boundary cycle itself, the inputs are copied straight into the committed registers on that edge. This takes priority over any stale shadow contents. pending ends at 0.
- **Blink.** frm counts frame boundaries 0..BLINK_FRAMES-1. When it wraps, blink_phase toggles.
- **Leading-zero mask (lz).** Active only when lz_blank=1; otherwise lz=0000.
  - lz[3] = (hexnum[15:12]==0).
  - lz[2] = lz[3] & (hexnum[11:8]==0).
  - lz[1] = lz[2] & (hexnum[7:4]==0).
  - lz[0] = 0; digit 0 is never suppressed.
- **Enable output.** enable = en_reg & ~(blink_reg & {4{blink_phase}}) & ~lz.
  - A masked digit is fully dark, including its decimal point, because its anode is off.
- **Output sources.** hexnum, point, scan and frame_start come directly from registers. enable is derived combinationally from registers and lz_blank only, never from load or data_in.

## Timing

- **Reset values** (asynchronous, while rst_n=0):
  - all outputs = 0;
  - div, scan, frm, blink_phase, pending = 0;
  - all shadow and committed registers = 0.
- **After reset release:**
  - scan changes on the edge following every SCAN_DIV-th cycle, and the first change is SCAN_DIV cycles after release;
  - frame_start first pulses 4*SCAN_DIV cycles after release;
  - frame period is 4*SCAN_DIV cycles.
- **Load latency:**
  - pending is high the cycle after load;
  - a committed value becomes visible on the same edge where scan goes 3→0, so the new data is always first shown on digit 0;
  - worst case from load to commit is 4*SCAN_DIV cycles.
- **Blink period:** each half-period lasts BLINK_FRAMES frames. blink_phase toggles on the same edge as the commit.
- **Reset mid-operation:** a pending update is discarded and blink_phase returns to 0.
- **Counter widths:** $clog2(SCAN_DIV) for div and $clog2(BLINK_FRAMES)+1 for frm. There is no arithmetic overflow, because every counter wraps by compare.

## Test plan

All scenarios use SCAN_DIV=4 and BLINK_FRAMES=2.

1. **Reset and scan sequence.**
   - Stimulus: hold rst_n=0, then release.
   - Required: all outputs 0 during reset. After release, scan steps 0,1,2,3,0 every 4 cycles, and frame_start pulses every 16 cycles, during scan==0 only.
2. **Deferred commit.**
   - Stimulus: load data_in=0x1234, enable_in=F, point_in=4'b0100 during scan==1.
   - Required: pending=1 on the next cycle. hexnum stays 0 until scan wraps to 0, then hexnum=0x1234, point=0100, enable=F, pending=0.
3. **Last load wins.**
   - Stimulus: within one frame, load 0x1111 and then 0x2222.
   - Required: only 0x2222 is ever seen on hexnum; 0x1111 never appears.
4. **Load on the boundary cycle.**
   - Stimulus: load 0xABCD on the cycle where div==3 and scan==3, with a stale 0x5555 already pending.
   - Required: hexnum=0xABCD when scan=0, and pending=0.
5. **Leading-zero suppression.**
   - Stimulus: lz_blank=1 with enable=F, first committing 0x0045, then 0x0000, then 0x1000.
   - Required: enable=0011, then 0001, then 1111. With lz_blank=0, enable=1111 for every value.
6. **Blink and reset.**
   - Stimulus: commit blink_in=0001 with enable_in=F; later pulse rst_n low.
   - Required: enable alternates 1111 and 1110, toggling every 2 frames (32 cycles). After the reset pulse, enable=0 and blink_phase restarts at 0.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_if.sv
// Host-side bundle for the seven-segment scan controller: display update
// request in, committed display state and scan status out.
interface seven_seg_scan_ctrl_if;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  point_in;
  logic [3:0]  enable_in;
  logic [3:0]  blink_in;
  logic        lz_blank;
  logic [15:0] hexnum;
  logic [3:0]  point;
  logic [3:0]  enable;
  logic [1:0]  scan;
  logic        frame_start;
  logic        pending;

  modport master (
    output load, data_in, point_in, enable_in, blink_in, lz_blank,
    input  hexnum, point, enable, scan, frame_start, pending
  );

  modport slave (
    input  load, data_in, point_in, enable_in, blink_in, lz_blank,
    output hexnum, point, enable, scan, frame_start, pending
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: refresh divider, frame-aligned
// display commit, per-digit blink and leading-zero suppression.
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input logic                 clk,
  input logic                 rst_n,
  seven_seg_scan_ctrl_if.slave bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = $clog2(BLINK_FRAMES) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       scan_r;
  logic             frame_start_r;
  logic [FRM_W-1:0] frm_r;
  logic             blink_phase_r;
  logic             pending_r;
  logic [15:0]      sh_hex_r;
  logic [3:0]       sh_point_r;
  logic [3:0]       sh_en_r;
  logic [3:0]       sh_blink_r;
  logic [15:0]      hex_r;
  logic [3:0]       point_r;
  logic [3:0]       en_r;
  logic [3:0]       blink_r;

  logic             tick_s;
  logic             boundary_s;
  logic [3:0]       lz_s;
  logic [3:0]       enable_s;

  // Digit 0 is never suppressed; higher digits go dark while all digits above them are zero.
  function automatic logic [3:0] lz_mask(input logic [15:0] hex, input logic lz_en);
    logic [3:0] m;
    m = 4'b0000;
    if (lz_en) begin
      m[3] = (hex[15:12] == 4'h0);
      m[2] = m[3] & (hex[11:8] == 4'h0);
      m[1] = m[2] & (hex[7:4] == 4'h0);
      m[0] = 1'b0;
    end else begin
      m = 4'b0000;
    end
    return m;
  endfunction

  // Divider terminal count and frame boundary decode.
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    boundary_s = tick_s && (scan_r == 2'd3);
  end

  // Refresh divider, scan index and frame-start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r         <= '0;
      scan_r        <= 2'd0;
      frame_start_r <= 1'b0;
    end else begin
      if (tick_s) begin
        div_r  <= '0;
        scan_r <= scan_r + 2'd1;
      end else begin
        div_r  <= div_r + DIV_W'(1);
      end
      frame_start_r <= boundary_s;
    end
  end

  // Frame counter driving the blink half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_r         <= '0;
      blink_phase_r <= 1'b0;
    end else if (boundary_s) begin
      if (frm_r == FRM_LAST) begin
        frm_r         <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        frm_r         <= frm_r + FRM_W'(1);
      end
    end
  end

  // Shadow capture and frame-aligned commit; a load on the boundary bypasses the stale shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= 1'b0;
      sh_hex_r   <= 16'h0000;
      sh_point_r <= 4'b0000;
      sh_en_r    <= 4'b0000;
      sh_blink_r <= 4'b0000;
      hex_r      <= 16'h0000;
      point_r    <= 4'b0000;
      en_r       <= 4'b0000;
      blink_r    <= 4'b0000;
    end else if (bus.load && boundary_s) begin
      pending_r  <= 1'b0;
      sh_hex_r   <= bus.data_in;
      sh_point_r <= bus.point_in;
      sh_en_r    <= bus.enable_in;
      sh_blink_r <= bus.blink_in;
      hex_r      <= bus.data_in;
      point_r    <= bus.point_in;
      en_r       <= bus.enable_in;
      blink_r    <= bus.blink_in;
    end else if (boundary_s && pending_r) begin
      pending_r  <= 1'b0;
      hex_r      <= sh_hex_r;
      point_r    <= sh_point_r;
      en_r       <= sh_en_r;
      blink_r    <= sh_blink_r;
    end else if (bus.load) begin
      pending_r  <= 1'b1;
      sh_hex_r   <= bus.data_in;
      sh_point_r <= bus.point_in;
      sh_en_r    <= bus.enable_in;
      sh_blink_r <= bus.blink_in;
    end
  end

  // Effective anode enable from committed state only.
  always_comb begin
    lz_s     = lz_mask(hex_r, bus.lz_blank);
    enable_s = en_r & ~(blink_r & {4{blink_phase_r}}) & ~lz_s;
  end

  assign bus.hexnum      = hex_r;
  assign bus.point       = point_r;
  assign bus.enable      = enable_s;
  assign bus.scan        = scan_r;
  assign bus.frame_start = frame_start_r;
  assign bus.pending     = pending_r;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_seven_seg_scan_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   cyc;
  int   nb;

  seven_seg_scan_ctrl_if bus ();

  seven_seg_scan_ctrl #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // cyc counts clock edges since reset release; nb counts frame boundaries.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc % 16 == 0) nb++;
  endtask

  task automatic run_to(input int m);
    for (int i = 0; i < 16; i++) begin
      if (cyc % 16 == m) break;
      step();
    end
  endtask

  // Loads on the boundary cycle so the values are committed at the next edge.
  task automatic commit(input logic [15:0] d, input logic [3:0] pt,
                        input logic [3:0] en, input logic [3:0] bl);
    run_to(15);
    bus.data_in   = d;
    bus.point_in  = pt;
    bus.enable_in = en;
    bus.blink_in  = bl;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_hex;
    logic [3:0]  exp_en;
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    nb         = 0;
    rst_n         = 1'b0;
    bus.load      = 1'b0;
    bus.data_in   = 16'h0000;
    bus.point_in  = 4'b0000;
    bus.enable_in = 4'b0000;
    bus.blink_in  = 4'b0000;
    bus.lz_blank  = 1'b0;

    // 1. reset state and scan sequence
    repeat (3) @(posedge clk);
    #1;
    check("rst_hexnum", bus.hexnum, 16'h0000);
    check("rst_point", {12'h000, bus.point}, 16'h0000);
    check("rst_enable", {12'h000, bus.enable}, 16'h0000);
    check("rst_scan", {14'h0000, bus.scan}, 16'h0000);
    check("rst_frame_start", {15'h0000, bus.frame_start}, 16'h0000);
    check("rst_pending", {15'h0000, bus.pending}, 16'h0000);
    rst_n = 1'b1;
    cyc   = 0;
    nb    = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      check("scan_seq", {14'h0000, bus.scan}, 16'((cyc / 4) % 4));
      check("frame_start_seq", {15'h0000, bus.frame_start}, 16'((cyc % 16 == 0) ? 1 : 0));
    end

    // 2. deferred commit, load during scan==1
    run_to(5);
    bus.data_in   = 16'h1234;
    bus.point_in  = 4'b0100;
    bus.enable_in = 4'hF;
    bus.blink_in  = 4'b0000;
    bus.load      = 1'b1;
    step();
    bus.load      = 1'b0;
    check("defer_pending_set", {15'h0000, bus.pending}, 16'h0001);
    check("defer_hex_held", bus.hexnum, 16'h0000);
    while (cyc % 16 != 0) begin
      step();
      if (cyc % 16 != 0) check("defer_hex_wait", bus.hexnum, 16'h0000);
    end
    check("defer_hexnum", bus.hexnum, 16'h1234);
    check("defer_point", {12'h000, bus.point}, 16'h0004);
    check("defer_enable", {12'h000, bus.enable}, 16'h000F);
    check("defer_pending_clr", {15'h0000, bus.pending}, 16'h0000);
    check("defer_scan0", {14'h0000, bus.scan}, 16'h0000);

    // 3. last load wins
    run_to(2);
    bus.data_in = 16'h1111;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    run_to(8);
    bus.data_in = 16'h2222;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cyc % 16 == 0) exp_hex = 16'h2222;
      else if (i == 0) exp_hex = 16'h1234;
      check("last_wins_hex", bus.hexnum, exp_hex);
      step();
    end

    // 4. load on the boundary cycle overrides stale shadow
    run_to(5);
    bus.data_in = 16'h5555;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    run_to(15);
    check("bnd_stale_pending", {15'h0000, bus.pending}, 16'h0001);
    bus.data_in = 16'hABCD;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    check("bnd_hexnum", bus.hexnum, 16'hABCD);
    check("bnd_pending", {15'h0000, bus.pending}, 16'h0000);
    check("bnd_scan", {14'h0000, bus.scan}, 16'h0000);
    step();
    check("bnd_hex_stays", bus.hexnum, 16'hABCD);

    // 5. leading-zero suppression
    bus.lz_blank = 1'b1;
    commit(16'h0045, 4'b0000, 4'hF, 4'b0000);
    check("lz_0045_on", {12'h000, bus.enable}, 16'h0003);
    bus.lz_blank = 1'b0;
    #1;
    check("lz_0045_off", {12'h000, bus.enable}, 16'h000F);
    bus.lz_blank = 1'b1;
    commit(16'h0000, 4'b0000, 4'hF, 4'b0000);
    check("lz_0000_on", {12'h000, bus.enable}, 16'h0001);
    bus.lz_blank = 1'b0;
    #1;
    check("lz_0000_off", {12'h000, bus.enable}, 16'h000F);
    bus.lz_blank = 1'b1;
    commit(16'h1000, 4'b0000, 4'hF, 4'b0000);
    check("lz_1000_on", {12'h000, bus.enable}, 16'h000F);
    bus.lz_blank = 1'b0;
    #1;
    check("lz_1000_off", {12'h000, bus.enable}, 16'h000F);

    // 6. blink, then reset mid-operation
    commit(16'h1000, 4'b0000, 4'hF, 4'b0001);
    for (int i = 0; i < 80; i++) begin
      exp_en = (((nb / 2) % 2) == 1) ? 4'b1110 : 4'b1111;
      check("blink_enable", {12'h000, bus.enable}, {12'h000, exp_en});
      step();
    end
    run_to(3);
    bus.data_in = 16'h7777;
    bus.load    = 1'b1;
    step();
    bus.load    = 1'b0;
    check("pre_rst_pending", {15'h0000, bus.pending}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_enable", {12'h000, bus.enable}, 16'h0000);
    check("mid_rst_hexnum", bus.hexnum, 16'h0000);
    check("mid_rst_pending", {15'h0000, bus.pending}, 16'h0000);
    check("mid_rst_scan", {14'h0000, bus.scan}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    nb    = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      check("post_rst_pending", {15'h0000, bus.pending}, 16'h0000);
      check("post_rst_hexnum", bus.hexnum, 16'h0000);
    end
    commit(16'h1000, 4'b0000, 4'hF, 4'b0001);
    check("post_rst_phase0", {12'h000, bus.enable}, 16'h000F);
    run_to(0);
    for (int i = 0; i < 17; i++) step();
    check("post_rst_phase1", {12'h000, bus.enable}, 16'h000E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
